// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared op codes, frame widths and FSM state encoding for spi_master
package spi_pkg;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  localparam int FRAME_W = 10;
  localparam int DATA_W  = 8;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    WAIT,
    READ,
    GAP
  } state_t;

endpackage

// File: rtl/spi_master_if.sv
// rtl/spi_master_if.sv - host-side command/response bundle of spi_master
interface spi_master_if;
  import spi_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              err;
  logic              busy;

  modport master (
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready, rsp_valid, rsp_data, err, busy
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data, err, busy
  );

endinterface

// File: rtl/spi_master_shifter.sv
// rtl/spi_master_shifter.sv - 10-bit TX parallel-load shifter and 8-bit RX sampler
module spi_master_shifter
  import spi_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [FRAME_W-1:0] load_data,
  input  logic               shift_en,
  input  logic               sample_en,
  input  logic               miso,
  output logic               tx_bit,
  output logic [DATA_W-1:0]  rx_data
);

  logic [FRAME_W-1:0] tx_sr;
  logic [DATA_W-1:0]  rx_sr;

  // TX frame: load {op,data}, then shift left so the MSB is always on the wire
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_sr <= '0;
    end else if (load) begin
      tx_sr <= load_data;
    end else if (shift_en) begin
      tx_sr <= {tx_sr[FRAME_W-2:0], 1'b0};
    end
  end

  // RX byte: MSB arrives first, so shift in from the LSB end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sr <= '0;
    end else if (sample_en) begin
      rx_sr <= {rx_sr[DATA_W-2:0], miso};
    end
  end

  assign tx_bit  = tx_sr[FRAME_W-1];
  assign rx_data = rx_sr;

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI master for the 10-bit slave/RAM frame protocol (option: SPI_MASTER_ORDER_CHECK_EN)
module spi_master
  import spi_pkg::*;
#(
  parameter int RD_LATENCY = 2,
  parameter int GAP_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  spi_master_if.master       host,
  output logic               MOSI,
  input  logic               MISO,
  output logic               SS_n
);

  localparam logic [3:0] SHIFT_LAST = 4'(FRAME_W - 1);
  localparam logic [3:0] READ_LAST  = 4'(DATA_W - 1);
  localparam logic [3:0] WAIT_LAST  = 4'(RD_LATENCY - 1);
  localparam logic [3:0] GAP_LAST   = 4'(GAP_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  op_q;
  logic        ready_en_q;
  logic        rsp_q, rsp_d;
  logic        err_q, err_d;
  logic        accept;
  logic        load, shift_en, sample_en;
  logic        order_ok;
  logic        tx_bit;
  logic [DATA_W-1:0] rx_data;

`ifdef SPI_MASTER_ORDER_CHECK_EN
  logic rd_flag_q;

  // Tracks that a read-addr preceded the next read-data; cleared once that read completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_flag_q <= 1'b0;
    end else if (accept && host.cmd_op == OP_RD_ADDR) begin
      rd_flag_q <= 1'b1;
    end else if (state_q == READ && cnt_q == 4'd0) begin
      rd_flag_q <= 1'b0;
    end
  end

  assign order_ok = (host.cmd_op != OP_RD_DATA) || rd_flag_q;
`else
  assign order_ok = 1'b1;
`endif

  // State, phase counter, latched op, and registered one-cycle pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      op_q       <= 2'b00;
      ready_en_q <= 1'b0;
      rsp_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ready_en_q <= 1'b1;
      rsp_q      <= rsp_d;
      err_q      <= err_d;
      if (accept) begin
        op_q <= host.cmd_op;
      end
    end
  end

  // Next state, counter reload and shifter controls
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load      = 1'b0;
    shift_en  = 1'b0;
    sample_en = 1'b0;
    rsp_d     = 1'b0;
    err_d     = 1'b0;
    accept    = (state_q == IDLE) && ready_en_q && host.cmd_valid;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (order_ok) begin
            load    = 1'b1;
            state_d = SHIFT;
            cnt_d   = SHIFT_LAST;
          end else begin
            err_d   = 1'b1;
            state_d = GAP;
            cnt_d   = GAP_LAST;
          end
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (cnt_q == 4'd0) begin
          if (op_q == OP_RD_DATA) begin
            if (RD_LATENCY == 0) begin
              state_d = READ;
              cnt_d   = READ_LAST;
            end else begin
              state_d = WAIT;
              cnt_d   = WAIT_LAST;
            end
          end else begin
            state_d = GAP;
            cnt_d   = GAP_LAST;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = READ;
          cnt_d   = READ_LAST;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      READ: begin
        sample_en = 1'b1;
        if (cnt_q == 4'd0) begin
          rsp_d   = 1'b1;
          state_d = GAP;
          cnt_d   = GAP_LAST;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      GAP: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  spi_master_shifter u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_data ({host.cmd_op, host.cmd_data}),
    .shift_en  (shift_en),
    .sample_en (sample_en),
    .miso      (MISO),
    .tx_bit    (tx_bit),
    .rx_data   (rx_data)
  );

  assign SS_n           = !(state_q == SHIFT || state_q == WAIT || state_q == READ);
  assign MOSI           = (state_q == SHIFT) && tx_bit;
  assign host.cmd_ready = (state_q == IDLE) && ready_en_q;
  assign host.busy      = (state_q != IDLE);
  assign host.rsp_valid = rsp_q;
  assign host.rsp_data  = rx_data;
  assign host.err       = err_q;

endmodule
